// File: rtl/gates_pkg.sv
// Shared gate definitions: op codes and a width-agnostic bitwise gate evaluator.
// Callers zero-extend operands to GATE_MAX_W and truncate the result back to their own width.
package gates_pkg;

    localparam int OP_W       = 3;
    localparam int GATE_MAX_W = 64;

    localparam logic [OP_W-1:0] OP_AND    = 3'd0;
    localparam logic [OP_W-1:0] OP_OR     = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND   = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR    = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR   = 3'd5;
    localparam logic [OP_W-1:0] OP_NOT_A  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS_A = 3'd7;

    function automatic logic [GATE_MAX_W-1:0] gate_eval(
        input logic [OP_W-1:0]       op,
        input logic [GATE_MAX_W-1:0] a,
        input logic [GATE_MAX_W-1:0] b
    );
        logic [GATE_MAX_W-1:0] y;
        y = '0;
        case (op)
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_NAND:   y = ~(a & b);
            OP_NOR:    y = ~(a | b);
            OP_XNOR:   y = ~(a ^ b);
            OP_NOT_A:  y = ~a;
            default:   y = a;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/gate_fifo2.sv
// Two-entry FIFO with a registered head; the head reads all-zero whenever the FIFO is empty.
// Pushes while full and pops while empty are ignored.
module gate_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    logic [1:0]    count;
    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // Clear vacated slots so an empty FIFO presents zeros downstream.
                    head  <= (count == 2'd2) ? tail : '0;
                    tail  <= '0;
                    count <= count - 2'd1;
                end
                2'b11: head <= din;  // only reachable at occupancy 1
                default: ;
            endcase
        end
    end

    assign dout  = head;
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/gate_alu_pipe.sv
// Registered bitwise gate ALU with single-beat and burst-accumulate modes, decoupled by a 2-entry output FIFO.
// Valid/ready: a beat or result moves on the rising edge where valid && ready; in_ready depends only on registered FIFO state.
module gate_alu_pipe
    import gates_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_count
);

    localparam int DW = WIDTH + 1 + CNT_W;

    logic             burst_active;
    logic [OP_W-1:0]  acc_op;
    logic [WIDTH-1:0] acc_y;
    logic [CNT_W-1:0] acc_cnt;

    logic             fire;
    logic             unary;
    logic [WIDTH-1:0] first_y;
    logic [WIDTH-1:0] next_y;
    logic [CNT_W-1:0] next_cnt;
    logic             push;
    logic [WIDTH-1:0] push_y;
    logic [CNT_W-1:0] push_cnt;
    logic [DW-1:0]    fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;

    assign fire = in_valid && in_ready;

    always_comb begin
        first_y  = WIDTH'(gate_eval(in_op, GATE_MAX_W'(in_a), GATE_MAX_W'(in_b)));
        // Unary ops use the new beat's operand rather than the running value.
        unary    = (acc_op == OP_NOT_A) || (acc_op == OP_PASS_A);
        next_y   = WIDTH'(gate_eval(acc_op, GATE_MAX_W'(unary ? in_a : acc_y), GATE_MAX_W'(in_a)));
        next_cnt = (acc_cnt == {CNT_W{1'b1}}) ? acc_cnt : acc_cnt + CNT_W'(1);
        push     = 1'b0;
        push_y   = first_y;
        push_cnt = CNT_W'(1);
        if (fire) begin
            if (!burst_active) begin
                push = !in_acc || in_last;
            end else if (in_last) begin
                push     = 1'b1;
                push_y   = next_y;
                push_cnt = next_cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_active <= 1'b0;
            acc_op       <= '0;
            acc_y        <= '0;
            acc_cnt      <= '0;
        end else if (fire) begin
            if (!burst_active) begin
                if (in_acc && !in_last) begin
                    burst_active <= 1'b1;
                    acc_op       <= in_op;
                    acc_y        <= first_y;
                    acc_cnt      <= CNT_W'(1);
                end
            end else if (in_last) begin
                burst_active <= 1'b0;
                acc_y        <= '0;
                acc_cnt      <= '0;
            end else begin
                acc_y   <= next_y;
                acc_cnt <= next_cnt;
            end
        end
    end

    gate_fifo2 #(.DW(DW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({push_y, (push_y == '0), push_cnt}),
        .pop   (out_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign out_y     = fifo_dout[DW-1 -: WIDTH];
    assign out_zero  = fifo_dout[CNT_W];
    assign out_count = fifo_dout[CNT_W-1:0];

endmodule

// File: tb/tb_gate_alu_pipe.sv
// Directed bench for gate_alu_pipe: single ops, accumulate bursts, backpressure, streaming and async reset.
module tb_gate_alu_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             in_acc;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic [CNT_W-1:0] out_count;

    int checks;
    int failures;

    gate_alu_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic acc, input logic last);
        in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last; in_valid = 1'b1;
    endtask

    // Drive one beat at the falling edge, let it transfer on the next rising edge, sample 1 time unit later.
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic acc, input logic last);
        @(negedge clk);
        drive(a, b, op, acc, last);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (out_valid !== 1'b0 || out_y !== 8'h00 || out_zero !== 1'b0 || out_count !== 4'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: valid=%b y=%h zero=%b cnt=%0d ready=%b, want 0 00 0 0 1",
                     out_valid, out_y, out_zero, out_count, in_ready);
        end
    endtask

    task automatic test_single_sweep;
        logic [7:0] exp_y [8];
        exp_y = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'hA5};
        out_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            beat(8'hA5, 8'h0F, 3'(op), 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_y !== exp_y[op] || out_count !== 4'd1 || out_zero !== 1'b0) begin
                failures++;
                $display("FAIL single_op%0d: valid=%b y=%h cnt=%0d zero=%b, want 1 %h 1 0",
                         op, out_valid, out_y, out_count, out_zero, exp_y[op]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_y !== 8'h00) begin
            failures++;
            $display("FAIL single_drain: valid=%b y=%h, want 0 00", out_valid, out_y);
        end
    endtask

    task automatic test_zero;
        out_ready = 1'b1;
        beat(8'hAA, 8'h55, 3'd0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_y !== 8'h00 || out_zero !== 1'b1 || out_count !== 4'd1) begin
            failures++;
            $display("FAIL zero_flag: valid=%b y=%h zero=%b cnt=%0d, want 1 00 1 1",
                     out_valid, out_y, out_zero, out_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_acc_xor;
        out_ready = 1'b1;
        beat(8'h01, 8'h02, 3'd2, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL acc_beat1: valid=%b, want 0", out_valid);
        end
        // in_b/in_op/in_acc deliberately noisy on later beats: they must be ignored.
        beat(8'h04, 8'hFF, 3'd0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL acc_beat2: valid=%b, want 0", out_valid);
        end
        beat(8'h08, 8'h77, 3'd1, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_y !== 8'h0F || out_count !== 4'd3 || out_zero !== 1'b0) begin
            failures++;
            $display("FAIL acc_result: valid=%b y=%h cnt=%0d zero=%b, want 1 0f 3 0",
                     out_valid, out_y, out_count, out_zero);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL acc_single_result: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_saturate;
        // PASS_A burst of 17 beats: count saturates at 15, result is last a.
        out_ready = 1'b1;
        beat(8'h01, 8'h00, 3'd7, 1'b1, 1'b0);
        for (int i = 2; i <= 16; i++) beat(8'(i), 8'h00, 3'd0, 1'b0, 1'b0);
        beat(8'h3C, 8'h00, 3'd0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_y !== 8'h3C || out_count !== 4'd15) begin
            failures++;
            $display("FAIL saturate: valid=%b y=%h cnt=%0d, want 1 3c 15", out_valid, out_y, out_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        beat(8'h01, 8'h00, 3'd1, 1'b0, 1'b0);
        beat(8'h02, 8'h00, 3'd1, 1'b0, 1'b0);
        @(negedge clk);
        drive(8'h04, 8'h00, 3'd1, 1'b0, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 8'h01) begin
            failures++;
            $display("FAIL bp_full: ready=%b valid=%b y=%h, want 0 1 01", in_ready, out_valid, out_y);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_y !== 8'h02 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_pop1: y=%h ready=%b, want 02 1", out_y, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_y !== 8'h04) begin
            failures++;
            $display("FAIL bp_third: valid=%b y=%h, want 1 04", out_valid, out_y);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int bad;
        bad = 0;
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            drive(8'(k * 16 + k), 8'h00, 3'd7, 1'b0, 1'b0);
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_y !== 8'(k * 16 + k)) begin
                failures++;
                $display("FAIL stream_%0d: ready=%b valid=%b y=%h, want 1 1 %h",
                         k, in_ready, out_valid, out_y, 8'(k * 16 + k));
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_drain: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        beat(8'h11, 8'h00, 3'd7, 1'b0, 1'b0);
        beat(8'hFF, 8'hF0, 3'd0, 1'b1, 1'b0);
        beat(8'h3C, 8'h00, 3'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_y !== 8'h00 || out_count !== 4'd0) begin
            failures++;
            $display("FAIL async_rst: valid=%b ready=%b y=%h cnt=%0d, want 0 1 00 0",
                     out_valid, in_ready, out_y, out_count);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        beat(8'hFF, 8'h0F, 3'd0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_y !== 8'h0F || out_count !== 4'd1) begin
            failures++;
            $display("FAIL post_rst: valid=%b y=%h cnt=%0d, want 1 0f 1", out_valid, out_y, out_count);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0; in_b = '0; in_op = '0; in_acc = 1'b0; in_last = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_single_sweep();
        test_zero();
        test_acc_xor();
        test_saturate();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
